// File: rtl/bsg_link_ddr_reset_sequencer.sv
// DDR link bring-up reset sequencer: assert, token pulse, release io_up, io_down, then core.
// Define BSG_LINK_RESET_SEQ_RETRY_EN for the link-alive timeout with automatic retries.
module bsg_link_ddr_reset_sequencer #(
   parameter int step_cycles_p    = 64,
   parameter int timeout_cycles_p = 1024,
   parameter int max_retries_p    = 3
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 start_i,
   input  logic                                 link_alive_i,
   output logic                                 io_up_link_reset_o,
   output logic                                 io_down_link_reset_o,
   output logic                                 async_token_reset_o,
   output logic                                 core_up_link_reset_o,
   output logic                                 core_down_link_reset_o,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 error_o,
   output logic [$clog2(max_retries_p+1)-1:0]   retry_count_o
);

   localparam int rc_w_lp  = $clog2(max_retries_p+1);
   localparam int cnt_w_lp = (step_cycles_p > 1) ? $clog2(step_cycles_p) : 1;
   localparam logic [cnt_w_lp-1:0] cnt_load_lp = cnt_w_lp'(step_cycles_p-1);

   typedef enum logic [2:0] {
      S_IDLE, S_ASSERT, S_TOKEN, S_TOKEN_OFF, S_UP_IO, S_DOWN_IO, S_DONE, S_ERROR
   } state_e;

   state_e              state_q, state_d;
   logic [cnt_w_lp-1:0] cnt_q, cnt_d;
   logic                step_done;
   logic                io_up_q, io_up_d, io_down_q, io_down_d, token_q, token_d;
   logic                core_q, core_d, busy_q, busy_d, done_q, done_d;

`ifdef BSG_LINK_RESET_SEQ_RETRY_EN
   localparam int tmr_w_lp = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
   logic [tmr_w_lp-1:0] tmr_q, tmr_d;
   logic                alive_q, alive_d;
   logic [rc_w_lp-1:0]  retry_q, retry_d;
   logic                error_q, error_d;
`else
   logic                unused_retry;
   assign unused_retry = link_alive_i | (timeout_cycles_p < 1);
`endif

   assign step_done = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef BSG_LINK_RESET_SEQ_RETRY_EN
      tmr_d   = tmr_q;
      alive_d = alive_q;
      retry_d = retry_q;
`endif
      case (state_q)
         S_IDLE:      if (start_i)   state_d = S_ASSERT;
         S_ASSERT:    if (step_done) state_d = S_TOKEN;
         S_TOKEN:     if (step_done) state_d = S_TOKEN_OFF;
         S_TOKEN_OFF: if (step_done) state_d = S_UP_IO;
         S_UP_IO:     if (step_done) state_d = S_DOWN_IO;
         S_DOWN_IO:   if (step_done) state_d = S_DONE;
         S_DONE: begin
            if (start_i) state_d = S_ASSERT;
`ifdef BSG_LINK_RESET_SEQ_RETRY_EN
            // alive (sticky or this cycle) takes priority over an expiring timer
            else if (alive_q || link_alive_i) alive_d = 1'b1;
            else if (tmr_q == tmr_w_lp'(timeout_cycles_p-1)) begin
               if (retry_q == rc_w_lp'(max_retries_p)) state_d = S_ERROR;
               else begin
                  retry_d = retry_q + rc_w_lp'(1);
                  state_d = S_ASSERT;
               end
            end
            else tmr_d = tmr_q + tmr_w_lp'(1);
`endif
         end
         S_ERROR:     if (start_i)   state_d = S_ASSERT;
         default:     state_d = S_IDLE;
      endcase

      if (busy_q && !step_done) cnt_d = cnt_q - cnt_w_lp'(1);
      if (state_d != state_q) begin
         cnt_d = cnt_load_lp;
`ifdef BSG_LINK_RESET_SEQ_RETRY_EN
         tmr_d   = '0;
         alive_d = 1'b0;
`endif
      end
`ifdef BSG_LINK_RESET_SEQ_RETRY_EN
      if (start_i && (state_q inside {S_IDLE, S_DONE, S_ERROR})) retry_d = '0;
      error_d = (state_d == S_ERROR);
`endif

      // outputs are decoded from the next state so every output is a flop
      io_up_d   = !(state_d inside {S_UP_IO, S_DOWN_IO, S_DONE});
      io_down_d = !(state_d inside {S_DOWN_IO, S_DONE});
      token_d   = (state_d == S_TOKEN);
      core_d    = (state_d != S_DONE);
      busy_d    = (state_d inside {S_ASSERT, S_TOKEN, S_TOKEN_OFF, S_UP_IO, S_DOWN_IO});
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         io_up_q   <= 1'b1;
         io_down_q <= 1'b1;
         token_q   <= 1'b0;
         core_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         io_up_q   <= io_up_d;
         io_down_q <= io_down_d;
         token_q   <= token_d;
         core_q    <= core_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef BSG_LINK_RESET_SEQ_RETRY_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tmr_q   <= '0;
         alive_q <= 1'b0;
         retry_q <= '0;
         error_q <= 1'b0;
      end else begin
         tmr_q   <= tmr_d;
         alive_q <= alive_d;
         retry_q <= retry_d;
         error_q <= error_d;
      end
   end

   assign error_o       = error_q;
   assign retry_count_o = retry_q;
`else
   assign error_o       = 1'b0;
   assign retry_count_o = '0;
`endif

   assign io_up_link_reset_o     = io_up_q;
   assign io_down_link_reset_o   = io_down_q;
   assign async_token_reset_o    = token_q;
   assign core_up_link_reset_o   = core_q;
   assign core_down_link_reset_o = core_q;
   assign busy_o                 = busy_q;
   assign done_o                 = done_q;

endmodule
